// File: rtl/mtime.sv
// Machine timer block: free-running 64-bit mtime with a clock prescaler,
// a 64-bit mtimecmp compare register, a registered interrupt-pending flag
// and a 32-bit fixed-latency load/store register port.
//
// Bus handshake: a request is a single cycle with req=1. There is no
// backpressure. Exactly one cycle later rsp_valid=1 with rd_data and err
// for that request. When rsp_valid=0, rd_data and err are 0. A new request
// may be issued every cycle.
module mtime #(
    parameter int unsigned DIVIDER    = 100,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strobe,
    output logic                  rsp_valid,
    output logic [31:0]           rd_data,
    output logic                  err,
    output logic [63:0]           time_o,
    output logic                  mtip
);

    localparam logic [15:0] PRESCALE_MAX = 16'(DIVIDER - 1);

    logic [15:0] prescale_q, prescale_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        mtip_q, mtip_d;
    logic        rsp_valid_q;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;

    logic        tick;
    logic [31:0] addr_ext;
    logic        addr_bad;
    logic [1:0]  reg_sel;
    logic        store;
    logic [31:0] rd_value;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return merged;
    endfunction

    // Address decode, read mux and next-state computation for all registers.
    always_comb begin
        addr_ext   = 32'(addr);
        addr_bad   = (addr_ext[1:0] != 2'b00) || (addr_ext >= 32'd16);
        reg_sel    = addr_ext[3:2];
        tick       = (prescale_q == PRESCALE_MAX);
        // A store with no lanes enabled touches nothing, so it must not
        // suppress the tick either.
        store      = req && we && !addr_bad && (|wr_strobe);

        prescale_d = tick ? 16'd0 : prescale_q + 16'd1;

        case (reg_sel)
            2'd0:    rd_value = mtime_q[31:0];
            2'd1:    rd_value = mtime_q[63:32];
            2'd2:    rd_value = mtimecmp_q[31:0];
            default: rd_value = mtimecmp_q[63:32];
        endcase

        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        // A store to mtime overrides this cycle's increment entirely:
        // unwritten lanes keep the pre-increment value.
        if (store) begin
            case (reg_sel)
                2'd0:    mtime_d    = {mtime_q[63:32], merge_lanes(mtime_q[31:0], wr_data, wr_strobe)};
                2'd1:    mtime_d    = {merge_lanes(mtime_q[63:32], wr_data, wr_strobe), mtime_q[31:0]};
                2'd2:    mtimecmp_d = {mtimecmp_q[63:32], merge_lanes(mtimecmp_q[31:0], wr_data, wr_strobe)};
                default: mtimecmp_d = {merge_lanes(mtimecmp_q[63:32], wr_data, wr_strobe), mtimecmp_q[31:0]};
            endcase
        end

        mtip_d    = (mtime_d >= mtimecmp_d);
        rd_data_d = (req && !we && !addr_bad) ? rd_value : 32'd0;
        err_d     = req && addr_bad;
    end

    // State and response registers; reset clears any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q  <= 16'd0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtip_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_data_q   <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            prescale_q  <= prescale_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            mtip_q      <= mtip_d;
            rsp_valid_q <= req;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;
    assign time_o    = mtime_q;
    assign mtip      = mtip_q;

endmodule

// File: tb/tb_mtime.sv
// Bench for mtime: two instances (DIVIDER=4 with 4 address bits, DIVIDER=1
// with 5 address bits) share one bus stimulus stream; each is compared every
// cycle against a cycle-count based reference model, plus directed checks.
module tb_mtime;

    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;

    logic        a_rsp, b_rsp, a_err, b_err, a_mtip, b_mtip;
    logic [31:0] a_rd, b_rd;
    logic [63:0] a_time, b_time;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    int unsigned m_cyc  [2];
    logic        e_rsp  [2];
    logic [31:0] e_rd   [2];
    logic        e_err  [2];
    logic        e_mtip [2];

    mtime #(.DIVIDER(DIV_A), .ADDR_WIDTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr[3:0]),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .rsp_valid(a_rsp),
        .rd_data(a_rd), .err(a_err), .time_o(a_time), .mtip(a_mtip)
    );

    mtime #(.DIVIDER(DIV_B), .ADDR_WIDTH(5)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .rsp_valid(b_rsp),
        .rd_data(b_rd), .err(b_err), .time_o(b_time), .mtip(b_mtip)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_time[k] = 64'd0;
            m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_cyc[k]  = 0;
            e_rsp[k]  = 1'b0;
            e_rd[k]   = 32'd0;
            e_err[k]  = 1'b0;
            e_mtip[k] = 1'b0;
        end
    endtask

    // One clock edge of the timer as described architecturally: mtime counts
    // every DIVIDER cycles since reset release, loads see the pre-edge value,
    // stores to mtime replace the increment.
    task automatic model_step(input int k);
        int          div;
        logic [4:0]  a;
        int          ix;
        logic        bad;
        logic        tick;
        logic        wrote_time;
        logic [63:0] pre_time;
        logic [63:0] pre_cmp;
        div        = (k == 0) ? DIV_A : DIV_B;
        a          = (k == 0) ? {1'b0, addr[3:0]} : addr;
        ix         = int'(a[3:2]);
        bad        = (a[1:0] != 2'b00) || (a >= 5'd16);
        tick       = ((m_cyc[k] % div) == div - 1);
        m_cyc[k]   = m_cyc[k] + 1;
        pre_time   = m_time[k];
        pre_cmp    = m_cmp[k];
        wrote_time = 1'b0;

        e_rsp[k] = req;
        e_err[k] = req && bad;
        e_rd[k]  = 32'd0;
        if (req && !we && !bad) begin
            case (ix)
                0: e_rd[k] = pre_time[31:0];
                1: e_rd[k] = pre_time[63:32];
                2: e_rd[k] = pre_cmp[31:0];
                default: e_rd[k] = pre_cmp[63:32];
            endcase
        end
        if (req && we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strobe[b]) begin
                    if (ix < 2) begin
                        m_time[k][ix*32 + b*8 +: 8] = wr_data[b*8 +: 8];
                        wrote_time = 1'b1;
                    end else begin
                        m_cmp[k][(ix-2)*32 + b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end
        if (tick && !wrote_time) m_time[k] = pre_time + 64'd1;
        e_mtip[k] = (m_time[k] >= m_cmp[k]);
    endtask

    task automatic check_all(input string tag);
        check({tag, ":A.rsp_valid"}, {63'd0, a_rsp},  {63'd0, e_rsp[0]});
        check({tag, ":A.rd_data"},   {32'd0, a_rd},   {32'd0, e_rd[0]});
        check({tag, ":A.err"},       {63'd0, a_err},  {63'd0, e_err[0]});
        check({tag, ":A.time_o"},    a_time,          m_time[0]);
        check({tag, ":A.mtip"},      {63'd0, a_mtip}, {63'd0, e_mtip[0]});
        check({tag, ":B.rsp_valid"}, {63'd0, b_rsp},  {63'd0, e_rsp[1]});
        check({tag, ":B.rd_data"},   {32'd0, b_rd},   {32'd0, e_rd[1]});
        check({tag, ":B.err"},       {63'd0, b_err},  {63'd0, e_err[1]});
        check({tag, ":B.time_o"},    b_time,          m_time[1]);
        check({tag, ":B.mtip"},      {63'd0, b_mtip}, {63'd0, e_mtip[1]});
    endtask

    // Drive one cycle of bus inputs, clock it, advance the model, compare.
    task automatic do_cycle(input string tag, input logic r, input logic w,
                            input logic [4:0] ad, input logic [31:0] d,
                            input logic [3:0] s);
        req       = r;
        we        = w;
        addr      = ad;
        wr_data   = d;
        wr_strobe = s;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        do_cycle(tag, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":A.rsp_valid"}, {63'd0, a_rsp},  64'd0);
        check({tag, ":A.rd_data"},   {32'd0, a_rd},   64'd0);
        check({tag, ":A.err"},       {63'd0, a_err},  64'd0);
        check({tag, ":A.time_o"},    a_time,          64'd0);
        check({tag, ":A.mtip"},      {63'd0, a_mtip}, 64'd0);
        check({tag, ":B.rsp_valid"}, {63'd0, b_rsp},  64'd0);
        check({tag, ":B.rd_data"},   {32'd0, b_rd},   64'd0);
        check({tag, ":B.err"},       {63'd0, b_err},  64'd0);
        check({tag, ":B.time_o"},    b_time,          64'd0);
        check({tag, ":B.mtip"},      {63'd0, b_mtip}, 64'd0);
    endtask

    initial begin
        logic [4:0] addr_tab [9];
        addr_tab = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h02, 5'h06, 5'h10, 5'h14, 5'h01};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 5'd0;
        wr_data = 32'd0; wr_strobe = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Release reset between edges; the next edge is the first counting edge.
        rst_n = 1'b1;

        // DIVIDER=4: three ticks in twelve cycles, then load mtime lo.
        for (int i = 0; i < 12; i++) idle("count");
        check("div4_time_after_12", a_time, 64'd3);
        do_cycle("load_lo", 1'b1, 1'b0, 5'h00, 32'd0, 4'h0);
        check("div4_load_rd", {32'd0, a_rd}, 64'd3);
        check("div4_load_rsp", {63'd0, a_rsp}, 64'd1);
        check("div4_load_err", {63'd0, a_err}, 64'd0);
        idle("after_load");
        check("rsp_drops", {63'd0, a_rsp}, 64'd0);

        // Carry from low word into high word (DIVIDER=1).
        do_cycle("st_lo_ones", 1'b1, 1'b1, 5'h00, 32'hFFFF_FFFF, 4'hF);
        do_cycle("st_hi_zero", 1'b1, 1'b1, 5'h04, 32'h0, 4'hF);
        idle("carry");
        check("div1_carry", b_time, 64'h1_0000_0000);

        // Compare and interrupt pending.
        do_cycle("st_cmp_lo", 1'b1, 1'b1, 5'h08, 32'd5, 4'hF);
        do_cycle("st_hi_0", 1'b1, 1'b1, 5'h04, 32'd0, 4'hF);
        do_cycle("st_lo_4", 1'b1, 1'b1, 5'h00, 32'd4, 4'hF);
        check("mtime_is_4", b_time, 64'd4);
        check("mtip_low", {63'd0, b_mtip}, 64'd0);
        do_cycle("st_cmp_hi0", 1'b1, 1'b1, 5'h0C, 32'd0, 4'hF);
        check("mtime_is_5", b_time, 64'd5);
        check("mtip_set", {63'd0, b_mtip}, 64'd1);
        do_cycle("st_cmp_hi1", 1'b1, 1'b1, 5'h0C, 32'd1, 4'hF);
        check("mtip_clear", {63'd0, b_mtip}, 64'd0);

        // Misaligned and out-of-range accesses, empty strobe.
        do_cycle("ld_misalign", 1'b1, 1'b0, 5'h02, 32'd0, 4'h0);
        check("misalign_err", {63'd0, b_err}, 64'd1);
        check("misalign_rd", {32'd0, b_rd}, 64'd0);
        do_cycle("st_misalign", 1'b1, 1'b1, 5'h06, 32'hDEAD_BEEF, 4'hF);
        check("st_misalign_err", {63'd0, a_err}, 64'd1);
        do_cycle("ld_oob", 1'b1, 1'b0, 5'h10, 32'd0, 4'h0);
        check("oob_err_b", {63'd0, b_err}, 64'd1);
        do_cycle("st_oob", 1'b1, 1'b1, 5'h14, 32'h0, 4'hF);
        do_cycle("st_nostrb", 1'b1, 1'b1, 5'h00, 32'h1234_5678, 4'h0);
        check("nostrb_err", {63'd0, b_err}, 64'd0);

        // Store on a tick cycle replaces the increment.
        do_cycle("st_1234", 1'b1, 1'b1, 5'h00, 32'h1234, 4'hF);
        do_cycle("st_byte0", 1'b1, 1'b1, 5'h00, 32'h0000_00AB, 4'h1);
        check("tick_priority", b_time, 64'h12AB);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            do_cycle("rand", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                     addr_tab[$urandom_range(0, 8)], d, 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-count with a request in flight.
        req = 1'b1; we = 1'b0; addr = 5'h08; wr_strobe = 4'h0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        req   = 1'b0;
        rst_n = 1'b1;
        model_reset();
        idle("post_rst");
        check("no_stray_rsp_a", {63'd0, a_rsp}, 64'd0);
        check("no_stray_rsp_b", {63'd0, b_rsp}, 64'd0);
        do_cycle("ld_cmp_lo", 1'b1, 1'b0, 5'h08, 32'd0, 4'h0);
        check("cmp_lo_ones", {32'd0, b_rd}, 64'hFFFF_FFFF);
        do_cycle("ld_cmp_hi", 1'b1, 1'b0, 5'h0C, 32'd0, 4'h0);
        check("cmp_hi_ones", {32'd0, a_rd}, 64'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) idle("post_rst_count");
        check("div4_time_post_rst", a_time, 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mtime.md
MTIME -- requirements
Module: mtime

Interface
REQ-001 SHALL have parameter DIVIDER, default 100, meaning clk cycles per mtime increment (range 1..65535).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4 (lexington::MTIME_ADDR_WIDTH), meaning byte-address bits decoded.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req  input  1  bus access request, one cycle per access.
REQ-006 SHALL have port we  input  1  1=store, 0=load; sampled with req.
REQ-007 SHALL have port addr  input  ADDR_WIDTH  byte address within the block.
REQ-008 SHALL have port wr_data  input  32  store data, little-endian byte lanes.
REQ-009 SHALL have port wr_strobe  input  4  byte-lane enables; bit i writes wr_data[8i+7:8i].
REQ-010 SHALL have port rsp_valid  output  1  response strobe for the previous cycle's req.
REQ-011 SHALL have port rd_data  output  32  load data, valid with rsp_valid.
REQ-012 SHALL have port err  output  1  access fault, valid with rsp_valid.
REQ-013 SHALL have port time_o  output  64  current mtime value, for time/timeh CSRs.
REQ-014 SHALL have port mtip  output  1  machine timer interrupt pending.

Function
REQ-015 SHALL implement registers: 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
REQ-016 SHALL keep a prescale counter 0..DIVIDER-1 that wraps to 0; a tick is the cycle it equals DIVIDER-1.
REQ-017 SHALL increment mtime by 1 on each tick, full 64-bit carry, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-018 SHALL, with DIVIDER=1, tick every cycle.
REQ-019 SHALL respond with fixed latency 1: rsp_valid=1 exactly the cycle after req=1, else 0; no backpressure, back-to-back req each cycle allowed.
REQ-020 SHALL return on load rd_data = register value at the req cycle (before that cycle's tick or write).
REQ-021 SHALL drive rd_data=0 on store responses and when rsp_valid=0.
REQ-022 SHALL flag err=1, with no state change, when addr[1:0]!=0 or addr>=16 (ADDR_WIDTH>4); rd_data=0 then.
REQ-023 SHALL apply stores in the req cycle, updating only strobed byte lanes; wr_strobe=0 is a legal no-op with err=0.
REQ-024 SHALL give a store to mtime priority over that cycle's tick: written lanes take wr_data, unwritten lanes keep the old value, and the increment is dropped for that cycle only.
REQ-025 SHALL NOT reset the prescale counter on mtime writes.
REQ-026 SHALL compute mtip as a register: mtip <= (mtime_next >= mtimecmp_next), 64-bit unsigned compare, so mtip is valid the cycle after any change.
REQ-027 SHALL drive time_o directly from the mtime register; it shall equal the value loads would return.

Reset
REQ-028 SHALL on rst_n=0, asynchronously: mtime=0, prescale=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, mtip=0, rsp_valid=0, rd_data=0, err=0.
REQ-029 SHALL drop any response pending for a req accepted in the cycle reset asserts; no rsp_valid after deassertion.
REQ-030 SHALL begin counting on the first rising edge with rst_n=1; the first tick is DIVIDER cycles later.

Verification
REQ-031 SHALL cover DIVIDER=4, reset release, 12 cycles: time_o=3; load 0x0 -> rd_data=3, rsp_valid one cycle later, err=0.
REQ-032 SHALL cover DIVIDER=1, store mtime lo=0xFFFF_FFFF, hi=0, idle 1 cycle: time_o=0x1_0000_0000 (carry into hi).
REQ-033 SHALL cover store 0x8=5 and 0xC=0 with mtime=4, DIVIDER=1: mtip=0, then mtip=1 the cycle after mtime reaches 5; store 0xC=1 clears mtip next cycle.
REQ-034 SHALL cover load 0x2 and store 0x6 with strobe 0xF: err=1, rsp_valid=1, rd_data=0, no register change.
REQ-035 SHALL cover store 0x0 strobe 0b0001 data 0xAB on a tick cycle with mtime=0x1234: result mtime=0x12AB (no increment).
REQ-036 SHALL cover rst_n low for 1 cycle mid-count with req pending: all outputs at reset values, no stray rsp_valid, mtimecmp reads back all ones.
